// File: rtl/ifmap_row_packer_pkg.sv
// ifmap_row_packer_pkg
//   Shared definitions for the ifmap row packer and its skid FIFO.
//   Contents: default widths, the FSM state type, tag bit positions and
//   the buffer entry width for the default data width.
package ifmap_row_packer_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_ADDR_WIDTH = 10;
    localparam int unsigned DEF_LEN_WIDTH  = 6;

    // Each buffer entry is {start_signal, end_signal, data}.
    localparam int unsigned TAG_WIDTH   = 2;
    localparam int unsigned ENTRY_WIDTH = DEF_DATA_WIDTH + TAG_WIDTH;
    localparam int unsigned START_BIT   = DEF_DATA_WIDTH + 1;
    localparam int unsigned END_BIT     = DEF_DATA_WIDTH;

    localparam int unsigned SKID_DEPTH  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/ifmap_row_packer_if.sv
// ifmap_row_packer_if
//   Bus bundle between the packer, the ifmap SRAM read port and the ifmap
//   circular buffer write port.
//   master (packer): drives sram_rd_en, sram_addr, buf_wr_en, buf_wdata;
//                    receives sram_rdata, buf_full.
//   slave  (memory side): the reverse.
interface ifmap_row_packer_if
    import ifmap_row_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);

    logic                            sram_rd_en;
    logic [ADDR_WIDTH-1:0]           sram_addr;
    logic [DATA_WIDTH-1:0]           sram_rdata;
    logic                            buf_full;
    logic                            buf_wr_en;
    logic [DATA_WIDTH+TAG_WIDTH-1:0] buf_wdata;

    modport master (
        output sram_rd_en, sram_addr, buf_wr_en, buf_wdata,
        input  sram_rdata, buf_full
    );

    modport slave (
        input  sram_rd_en, sram_addr, buf_wr_en, buf_wdata,
        output sram_rdata, buf_full
    );

endinterface

// File: rtl/ifmap_row_packer_skid_fifo.sv
// packer_skid_fifo
//   Two-entry FIFO that absorbs SRAM read data still in flight when the
//   downstream buffer stalls. Push and pop in the same cycle both take effect.
//   Ports: clk, rst (async, active-high), push/din, pop, dout (head entry,
//   straight from a register), count (0..2), empty, full.
//   Push while full without a pop, or pop while empty, is ignored.
module packer_skid_fifo
    import ifmap_row_packer_pkg::*;
#(
    parameter int unsigned WIDTH = ENTRY_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'd2) || do_pop);
        case ({do_push, do_pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = din;
                else                 tail_d = din;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; with one entry the new data becomes head.
                if (count_q == 2'd1) begin
                    head_d = din;
                end else begin
                    head_d = tail_q;
                    tail_d = din;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign dout  = head_q;
    assign count = count_q;
    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'd2);

endmodule

// File: rtl/ifmap_row_packer.sv
// ifmap_row_packer
//   Reads num_rows x row_len words from the ifmap SRAM (1-cycle read latency),
//   tags each with {start, end} of row and writes them into the ifmap circular
//   buffer, throttled by buf_full. One start pulse runs a whole tile.
//   Ports: clk, rst (async, active-high), start (sampled in IDLE only),
//   base_addr/row_pitch/row_len/num_rows (latched on start; 0 lengths act as 1),
//   busy (start accepted until back in IDLE), done (1-cycle pulse after the
//   final buffer write), bus (master side: SRAM read port + buffer write port).
module ifmap_row_packer
    import ifmap_row_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] row_pitch,
    input  logic [LEN_WIDTH-1:0]  row_len,
    input  logic [LEN_WIDTH-1:0]  num_rows,
    output logic                  busy,
    output logic                  done,
    ifmap_row_packer_if.master    bus
);

    localparam int unsigned EW = DATA_WIDTH + TAG_WIDTH;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [ADDR_WIDTH-1:0] pitch_q, pitch_d;
    logic [LEN_WIDTH-1:0]  len_last_q, len_last_d;
    logic [LEN_WIDTH-1:0]  rows_last_q, rows_last_d;
    logic [LEN_WIDTH-1:0]  col_q, col_d;
    logic [LEN_WIDTH-1:0]  row_q, row_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            tag_q, tag_d;

    logic                  rd_en;
    logic                  pop;
    logic                  col_last, row_last;
    logic [1:0]            occupancy;
    logic [1:0]            fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [EW-1:0]         fifo_head;

    packer_skid_fifo #(
        .WIDTH (EW)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .din   ({tag_q, bus.sram_rdata}),
        .pop   (pop),
        .dout  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign pop      = !fifo_empty && !bus.buf_full;
    assign col_last = (col_q == len_last_q);
    assign row_last = (row_q == rows_last_q);

    // Slots that will be committed once this cycle's pop retires. Crediting the
    // pop keeps one read per cycle flowing while the buffer accepts, yet FIFO
    // plus in-flight data can never exceed the two skid slots.
    assign occupancy = fifo_count + {1'b0, inflight_q} - {1'b0, pop};

    always_comb begin
        state_d     = state_q;
        row_base_d  = row_base_q;
        pitch_d     = pitch_q;
        len_last_d  = len_last_q;
        rows_last_d = rows_last_q;
        col_d       = col_q;
        row_d       = row_q;
        inflight_d  = 1'b0;
        tag_d       = tag_q;
        rd_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    row_base_d  = base_addr;
                    pitch_d     = row_pitch;
                    len_last_d  = (row_len == '0)  ? '0 : row_len  - LEN_WIDTH'(1);
                    rows_last_d = (num_rows == '0) ? '0 : num_rows - LEN_WIDTH'(1);
                    col_d       = '0;
                    row_d       = '0;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (occupancy < 2'd2) begin
                    rd_en      = 1'b1;
                    inflight_d = 1'b1;
                    tag_d      = {(col_q == '0), col_last};
                    if (col_last) begin
                        col_d = '0;
                        if (row_last) begin
                            state_d = ST_DRAIN;
                        end else begin
                            row_d      = row_q + LEN_WIDTH'(1);
                            row_base_d = row_base_q + pitch_q;
                        end
                    end else begin
                        col_d = col_q + LEN_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Last read has returned and the last entry leaves this cycle.
                if (!inflight_q && (fifo_empty || (fifo_count == 2'd1 && pop))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_base_q  <= '0;
            pitch_q     <= '0;
            len_last_q  <= '0;
            rows_last_q <= '0;
            col_q       <= '0;
            row_q       <= '0;
            inflight_q  <= 1'b0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            row_base_q  <= row_base_d;
            pitch_q     <= pitch_d;
            len_last_q  <= len_last_d;
            rows_last_q <= rows_last_d;
            col_q       <= col_d;
            row_q       <= row_d;
            inflight_q  <= inflight_d;
            tag_q       <= tag_d;
        end
    end

    // Address wraps modulo 2^ADDR_WIDTH by truncation of the sum.
    assign bus.sram_rd_en = rd_en;
    assign bus.sram_addr  = rd_en ? (row_base_q + ADDR_WIDTH'(col_q)) : '0;
    assign bus.buf_wr_en  = pop;
    assign bus.buf_wdata  = fifo_head;
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_ifmap_row_packer.sv
module tb_ifmap_row_packer;
    import ifmap_row_packer_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] base_addr;
    logic [9:0] row_pitch;
    logic [5:0] row_len;
    logic [5:0] num_rows;
    logic       busy;
    logic       done;

    ifmap_row_packer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) bus ();

    ifmap_row_packer #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (10),
        .LEN_WIDTH  (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .row_pitch (row_pitch),
        .row_len   (row_len),
        .num_rows  (num_rows),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem [1024];
    logic        rd_pend = 1'b0;
    logic [9:0]  rd_addr = '0;

    logic [17:0] wr_log [$];
    int          wr_cyc [$];
    int          rd_log [$];
    logic [17:0] exp_q  [$];
    int          exp_a  [$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          full_wr_cnt = 0;
    int          occ_viol = 0;

    // Sample DUT outputs mid-cycle, away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.buf_wr_en) begin
            wr_log.push_back(bus.buf_wdata);
            wr_cyc.push_back(cyc);
            if (bus.buf_full) full_wr_cnt = full_wr_cnt + 1;
        end
        if (bus.sram_rd_en) rd_log.push_back(int'(bus.sram_addr));
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (int'(rd_log.size()) - int'(wr_log.size()) > 2) occ_viol = occ_viol + 1;
        rd_pend = bus.sram_rd_en;
        rd_addr = bus.sram_addr;
    end

    // SRAM model: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_pend) bus.sram_rdata <= mem[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        wr_log.delete();
        wr_cyc.delete();
        rd_log.delete();
        exp_q.delete();
        exp_a.delete();
        done_cnt = 0;
    endtask

    task automatic run_tile(input int b, input int p, input int l, input int r);
        base_addr = 10'(b);
        row_pitch = 10'(p);
        row_len   = 6'(l);
        num_rows  = 6'(r);
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
        // Scramble config to show it was latched at start.
        base_addr = 10'h155;
        row_pitch = 10'h2AA;
        row_len   = 6'd17;
        num_rows  = 6'd9;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) tick(1);
        tick(2);
        check("done_once", done_cnt, 1);
        check("busy_after_done", busy, 0);
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int i = 0; i < budget && int'(wr_log.size()) < n; i++) tick(1);
        check("writes_reached", (int'(wr_log.size()) >= n), 1);
    endtask

    task automatic compare_writes(input string name);
        check({name, "_wr_count"}, wr_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
            check($sformatf("%s_wr[%0d]", name, i), wr_log[i], exp_q[i]);
    endtask

    task automatic compare_reads(input string name);
        check({name, "_rd_count"}, rd_log.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < rd_log.size(); i++)
            check($sformatf("%s_rd[%0d]", name, i), rd_log[i], exp_a[i]);
    endtask

    task automatic load_t1_exp();
        exp_q.push_back(18'h20017);
        exp_q.push_back(18'h00029);
        exp_q.push_back(18'h1FFD3);
    endtask

    task automatic load_t2_exp();
        exp_q.push_back(18'h2A004);
        exp_q.push_back(18'h1A005);
        exp_q.push_back(18'h2A00C);
        exp_q.push_back(18'h1A00D);
        exp_a.push_back(4);
        exp_a.push_back(5);
        exp_a.push_back(12);
        exp_a.push_back(13);
    endtask

    initial begin
        int snap;
        for (int a = 0; a < 1024; a++) mem[a] = 16'hA000 + 16'(a);
        mem[0] = 16'h0017;
        mem[1] = 16'h0029;
        mem[2] = 16'hFFD3;

        rst          = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        row_pitch    = '0;
        row_len      = '0;
        num_rows     = '0;
        bus.buf_full = 1'b0;
        tick(3);
        check("rst_rd_en", bus.sram_rd_en, 0);
        check("rst_addr", bus.sram_addr, 0);
        check("rst_wr_en", bus.buf_wr_en, 0);
        check("rst_wdata", bus.buf_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        tick(2);

        // T1: single row of three, back-to-back writes.
        clear_logs();
        load_t1_exp();
        run_tile(0, 0, 3, 1);
        wait_done(50);
        compare_writes("t1");
        if (wr_cyc.size() == 3) begin
            check("t1_gap01", wr_cyc[1] - wr_cyc[0], 1);
            check("t1_gap12", wr_cyc[2] - wr_cyc[1], 1);
            check("t1_done_lat", done_cyc - wr_cyc[2], 1);
        end

        // T2: two rows with pitch.
        clear_logs();
        load_t2_exp();
        run_tile(4, 8, 2, 2);
        wait_done(50);
        compare_writes("t2");
        compare_reads("t2");

        // T3: T1 with buf_full held for 10 cycles after the first write.
        clear_logs();
        load_t1_exp();
        run_tile(0, 0, 3, 1);
        wait_writes(1, 50);
        bus.buf_full = 1'b1;
        snap = wr_log.size();
        tick(10);
        check("t3_no_write_while_full", wr_log.size(), snap);
        bus.buf_full = 1'b0;
        wait_done(50);
        compare_writes("t3");

        // T3b: full before start; reads stop at the two skid slots.
        clear_logs();
        bus.buf_full = 1'b1;
        for (int e = 0; e < 8; e++)
            exp_q.push_back({(e == 0), (e == 7), 16'hA0C8 + 16'(e)});
        run_tile(200, 0, 8, 1);
        tick(20);
        check("t3b_reads_stalled", rd_log.size(), 2);
        check("t3b_no_writes", wr_log.size(), 0);
        check("t3b_busy", busy, 1);
        bus.buf_full = 1'b0;
        wait_done(80);
        compare_writes("t3b");

        // T4: row_len 1 -> every entry tagged start and end.
        clear_logs();
        exp_q.push_back(18'h3A064);
        exp_q.push_back(18'h3A067);
        exp_q.push_back(18'h3A06A);
        run_tile(100, 3, 1, 3);
        wait_done(50);
        compare_writes("t4");

        // T5: address wrap at the top of the SRAM.
        clear_logs();
        exp_a.push_back(1022);
        exp_a.push_back(1023);
        exp_a.push_back(0);
        exp_a.push_back(1);
        exp_q.push_back(18'h2A3FE);
        exp_q.push_back(18'h0A3FF);
        exp_q.push_back(18'h00017);
        exp_q.push_back(18'h10029);
        run_tile(1022, 0, 4, 1);
        wait_done(50);
        compare_reads("t5");
        compare_writes("t5");

        // T7: zero lengths act as one.
        clear_logs();
        exp_q.push_back(18'h3A032);
        run_tile(50, 0, 0, 0);
        wait_done(50);
        compare_writes("t7");

        // T6: reset mid-tile, then a clean rerun.
        clear_logs();
        run_tile(4, 8, 2, 2);
        wait_writes(2, 50);
        rst = 1'b1;
        #1;
        check("t6_rd_en", bus.sram_rd_en, 0);
        check("t6_wr_en", bus.buf_wr_en, 0);
        check("t6_wdata", bus.buf_wdata, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        tick(1);
        rst = 1'b0;
        tick(5);
        check("t6_no_done", done_cnt, 0);
        clear_logs();
        load_t2_exp();
        run_tile(4, 8, 2, 2);
        wait_done(50);
        compare_writes("t6_rerun");
        compare_reads("t6_rerun");

        check("never_write_while_full", full_wr_cnt, 0);
        check("skid_occupancy_le2", occ_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
